// File: rtl/mdu_pkg.sv
// Shared opcode and state encodings for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath: shift-add (multiply, right shift)
// or restoring trial-subtract (divide, left shift) on a 2k-bit accumulator.
module mdu_step #(
    parameter int k = 32
) (
    input  logic           is_div,
    input  logic [2*k-1:0] acc,
    input  logic [k-1:0]   operand,
    output logic [2*k-1:0] acc_next
);

    logic [k:0] sum;
    logic [k:0] rem_sh;
    logic [k:0] trial;

    always_comb begin
        sum      = {1'b0, acc[2*k-1:k]} + {1'b0, operand};
        rem_sh   = acc[2*k-1:k-1];
        // rem < divisor keeps the trial difference inside a signed k+1-bit range
        trial    = rem_sh - {1'b0, operand};
        acc_next = acc;
        if (is_div) begin
            if (!trial[k]) begin
                acc_next = {trial[k-1:0], acc[k-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[k-1:0], acc[k-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_next = {sum, acc[k-1:1]};
            end else begin
                acc_next = {1'b0, acc[2*k-1:k], acc[k-1:1]};
            end
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One bit per cycle on operand magnitudes, signs applied in a final fix-up cycle.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int n     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_start,
    input  logic [1:0]   in_op,
    input  logic [n-1:0] input_a,
    input  logic [n-1:0] input_b,
    input  logic         in_mthi,
    input  logic         in_mtlo,
    input  logic [n-1:0] in_wdata,
    output logic         out_busy,
    output logic         out_done,
    output logic [n-1:0] out_hi,
    output logic [n-1:0] out_lo
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(n - 1);

    mdu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [2*n-1:0]   acc_reg, acc_next;
    logic [n-1:0]     opnd_reg, raw_a_reg, hi_reg, lo_reg;
    logic             sign_a_reg, sign_b_reg, is_div_reg, div_zero_reg, done_reg;

    logic             signed_op;
    logic [n-1:0]     mag_a, mag_b;
    logic [2*n-1:0]   prod_fix;
    logic [n-1:0]     quot_fix, rem_fix;

    always_comb begin
        signed_op = op_is_signed(in_op);
        mag_a     = (signed_op && input_a[n-1]) ? -input_a : input_a;
        mag_b     = (signed_op && input_b[n-1]) ? -input_b : input_b;
        prod_fix  = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
        quot_fix  = (sign_a_reg ^ sign_b_reg) ? -acc_reg[n-1:0] : acc_reg[n-1:0];
        rem_fix   = sign_a_reg ? -acc_reg[2*n-1:n] : acc_reg[2*n-1:n];
    end

    mdu_step #(.k(n)) u_step (
        .is_div   (is_div_reg),
        .acc      (acc_reg),
        .operand  (opnd_reg),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_start) state_next = ST_RUN;
            ST_RUN:  if (cnt_reg == LAST) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The launch cycle itself is not stalled; busy covers edges E0+1 .. E0+n.
    always_comb begin
        out_busy = (state_reg == ST_FIX) || ((state_reg == ST_RUN) && (cnt_reg != '0));
        out_done = done_reg;
        out_hi   = hi_reg;
        out_lo   = lo_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            acc_reg      <= '0;
            opnd_reg     <= '0;
            raw_a_reg    <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            sign_a_reg   <= 1'b0;
            sign_b_reg   <= 1'b0;
            is_div_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_start) begin
                        cnt_reg      <= '0;
                        sign_a_reg   <= signed_op & input_a[n-1];
                        sign_b_reg   <= signed_op & input_b[n-1];
                        is_div_reg   <= op_is_div(in_op);
                        div_zero_reg <= (input_b == '0);
                        raw_a_reg    <= input_a;
                        // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
                        if (op_is_div(in_op)) begin
                            acc_reg  <= {{n{1'b0}}, mag_a};
                            opnd_reg <= mag_b;
                        end else begin
                            acc_reg  <= {{n{1'b0}}, mag_b};
                            opnd_reg <= mag_a;
                        end
                    end else begin
                        if (in_mthi) hi_reg <= in_wdata;
                        if (in_mtlo) lo_reg <= in_wdata;
                    end
                end
                ST_RUN: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                ST_FIX: begin
                    done_reg <= 1'b1;
                    if (is_div_reg) begin
                        if (div_zero_reg) begin
                            lo_reg <= '1;
                            hi_reg <= raw_a_reg;
                        end else begin
                            lo_reg <= quot_fix;
                            hi_reg <= rem_fix;
                        end
                    end else begin
                        {hi_reg, lo_reg} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_mdu_iterative;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_start;
    logic [1:0]  in_op;
    logic [31:0] input_a, input_b;
    logic        in_mthi, in_mtlo;
    logic [31:0] in_wdata;
    logic        out_busy, out_done;
    logic [31:0] out_hi, out_lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mdu_iterative #(.n(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_start (in_start),
        .in_op    (in_op),
        .input_a  (input_a),
        .input_b  (input_b),
        .in_mthi  (in_mthi),
        .in_mtlo  (in_mtlo),
        .in_wdata (in_wdata),
        .out_busy (out_busy),
        .out_done (out_done),
        .out_hi   (out_hi),
        .out_lo   (out_lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: returns {HI, LO} from the architectural definition.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        int          q, rm;
        logic [63:0] r;
        case (op)
            MULT: begin
                sa = $signed(a);
                sb = $signed(b);
                r  = sa * sb;
            end
            MULTU: r = {32'b0, a} * {32'b0, b};
            DIV: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    q  = $signed(a) / $signed(b);
                    rm = $signed(a) % $signed(b);
                    r  = {rm[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        in_op    = op;
        input_a  = a;
        input_b  = b;
        in_start = 1'b1;
        @(posedge clk); #1;
        in_start = 1'b0;
        input_a  = $urandom;
        input_b  = $urandom;
    endtask

    task automatic wait_done(input int inject_at, output int cyc, output int busy_cnt, output bit seen);
        cyc = 0;
        busy_cnt = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == inject_at) begin
                in_start = 1'b1;
                in_op    = DIVU;
                in_mtlo  = 1'b1;
                in_wdata = 32'hDEAD_BEEF;
            end else if (cyc == inject_at + 1) begin
                in_start = 1'b0;
                in_mtlo  = 1'b0;
            end
            if (out_busy) busy_cnt++;
            if (out_done) seen = 1'b1;
        end
    endtask

    task automatic run_check(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int          cyc, busy_cnt;
        bit          seen;
        exp = model(op, a, b);
        launch(op, a, b);
        wait_done(-1, cyc, busy_cnt, seen);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h (exp hi=%h lo=%h) cycles=%0d busy=%0d",
                 op, a, b, out_hi, out_lo, exp[63:32], exp[31:0], cyc, busy_cnt);
        check("done_seen", 64'(seen), 64'd1);
        check("latency", 64'(cyc), 64'd33);
        check("busy_cycles", 64'(busy_cnt), 64'd32);
        check("busy_at_done", 64'(out_busy), 64'd0);
        check("hi", 64'(out_hi), 64'(exp[63:32]));
        check("lo", 64'(out_lo), 64'(exp[31:0]));
        @(posedge clk); #1;
        check("done_one_cycle", 64'(out_done), 64'd0);
    endtask

    initial begin
        logic [63:0] exp;
        int          cyc, busy_cnt, done_cnt;
        bit          seen;
        logic [1:0]  op;
        logic [31:0] a, b;

        rst = 1'b1; in_start = 1'b0; in_op = MULT; input_a = '0; input_b = '0;
        in_mthi = 1'b0; in_mtlo = 1'b0; in_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(out_busy), 64'd0);
        check("rst_done", 64'(out_done), 64'd0);
        check("rst_hi", 64'(out_hi), 64'd0);
        check("rst_lo", 64'(out_lo), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_check(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_check(MULT,  32'hFFFF_FFFD, 32'd7);
        run_check(DIV,   32'hFFFF_FFF9, 32'd2);
        run_check(DIVU,  32'd7, 32'd0);
        run_check(DIV,   32'hFFFF_FFF0, 32'd0);
        run_check(DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_check(MULT,  32'h8000_0000, 32'h8000_0000);

        // Start and move while busy are both ignored.
        launch(MULT, 32'd5, 32'd6);
        wait_done(10, cyc, busy_cnt, seen);
        $display("ignore-while-busy: hi=%h lo=%h cycles=%0d", out_hi, out_lo, cyc);
        check("ign_seen", 64'(seen), 64'd1);
        check("ign_latency", 64'(cyc), 64'd33);
        check("ign_hi", 64'(out_hi), 64'd0);
        check("ign_lo", 64'(out_lo), 64'd30);
        @(posedge clk); #1;
        check("ign_no_second_op", 64'(out_busy), 64'd0);

        in_mthi = 1'b1; in_wdata = 32'h0000_1234;
        @(posedge clk); #1;
        in_mthi = 1'b0;
        $display("mthi: hi=%h lo=%h", out_hi, out_lo);
        check("mthi_hi", 64'(out_hi), 64'h1234);
        check("mthi_lo", 64'(out_lo), 64'd30);

        in_mthi = 1'b1; in_mtlo = 1'b1; in_wdata = 32'hABCD_0123;
        @(posedge clk); #1;
        in_mthi = 1'b0; in_mtlo = 1'b0;
        $display("mthi+mtlo: hi=%h lo=%h", out_hi, out_lo);
        check("both_hi", 64'(out_hi), 64'hABCD_0123);
        check("both_lo", 64'(out_lo), 64'hABCD_0123);

        // Start wins over a simultaneous move.
        exp = model(DIVU, 32'd100, 32'd7);
        in_mthi = 1'b1; in_wdata = 32'h5555_5555;
        launch(DIVU, 32'd100, 32'd7);
        in_mthi = 1'b0;
        wait_done(-1, cyc, busy_cnt, seen);
        $display("start+mthi: hi=%h lo=%h", out_hi, out_lo);
        check("sw_seen", 64'(seen), 64'd1);
        check("sw_hi", 64'(out_hi), 64'(exp[63:32]));
        check("sw_lo", 64'(out_lo), 64'(exp[31:0]));

        // Reset mid-operation aborts without a done pulse.
        @(posedge clk); #1;
        launch(DIVU, $urandom, $urandom_range(1, 1000));
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("mid-op reset: busy=%0d hi=%h lo=%h", out_busy, out_hi, out_lo);
        check("abort_busy", 64'(out_busy), 64'd0);
        check("abort_hi", 64'(out_hi), 64'd0);
        check("abort_lo", 64'(out_lo), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        run_check(MULT, 32'hFFFF_FF00, 32'h0000_0123);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'($urandom_range(1, 16));
                default: ;
            endcase
            run_check(op, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
